dual_issue_hazard_ctrl: RTL and testbench

Issue-stage hazard controller for the dual-issue superscalar pipeline. It sits at the ID_RF → RF_EX boundary, beside the forwarding controller. It resolves hazards that forwarding cannot cover:

- load-use dependencies on loads currently in RF_EX;
- intra-pair RAW dependencies between slot 1 and slot 2 of the same fetch pair.

It does this by stalling the front end, inserting bubbles, or splitting a pair across two cycles. Branch flushes from EX override everything.

---
 rtl/dual_issue_hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dual_issue_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// dual_issue_hazard_ctrl
//
// Issue-stage hazard controller for the dual-issue pipeline. It sits at the
// ID_RF -> RF_EX boundary and resolves the hazards that forwarding cannot
// cover:
//   - load-use: an ID_RF source reads a load that is still in RF_EX
//     (one bubble, front end held);
//   - intra-pair RAW: slot 2 reads slot 1's destination
//     (the pair is split, slot 1 issues in cycle N and slot 2 in cycle N+1).
// A branch/jump flush from EX overrides every other decision.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles / split_count are saturating event counters
//   undefined -> no counter registers; both ports are tied to zero
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   src{1,2}_{1,2}_ID_RF [3:0]       operand descriptors, [3]=used, [2:0]=reg
//   dest_{1,2}_ID_RF [2:0]           pair destination registers
//   wb_{1,2}_ID_RF                   pair slot writes a register
//   valid{1,2}_ID_RF                 pair slot holds a real instruction
//   dest_{1,2}_RF_EX [2:0]           destinations currently in RF_EX
//   load_{1,2}_RF_EX                 RF_EX slot is a load
//   valid{1,2}_RF_EX                 RF_EX slot valid
//   flush                            redirect from EX
//   hold_ID_RF                       freeze PC, IF_ID and ID_RF this cycle
//   issue_valid{1,2}                 valid bits written into RF_EX
//   split_active                     FSM is in SPLIT (state debug view)
//   stall_cycles [CNT_W-1:0]         load-use stall cycle count
//   split_count  [CNT_W-1:0]         split-issue event count
//
// All outputs are combinational from the state register and current inputs.
// -----------------------------------------------------------------------------
module dual_issue_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       src1_1_ID_RF,
  input  logic [3:0]       src2_1_ID_RF,
  input  logic [3:0]       src1_2_ID_RF,
  input  logic [3:0]       src2_2_ID_RF,
  input  logic [2:0]       dest_1_ID_RF,
  input  logic [2:0]       dest_2_ID_RF,
  input  logic             wb_1_ID_RF,
  input  logic             wb_2_ID_RF,
  input  logic             valid1_ID_RF,
  input  logic             valid2_ID_RF,
  input  logic [2:0]       dest_1_RF_EX,
  input  logic [2:0]       dest_2_RF_EX,
  input  logic             load_1_RF_EX,
  input  logic             load_2_RF_EX,
  input  logic             valid1_RF_EX,
  input  logic             valid2_RF_EX,
  input  logic             flush,
  output logic             hold_ID_RF,
  output logic             issue_valid1,
  output logic             issue_valid2,
  output logic             split_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] split_count
);

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic ld1_live, ld2_live;
  logic lu_slot1, lu_slot2;
  logic raw12;
  logic stall_inc, split_inc;

  function automatic logic src_hit(input logic [3:0] s, input logic [2:0] d);
    return s[3] && (s[2:0] == d);
  endfunction

  // Only loads still sitting in RF_EX matter; anything older is forwarded.
  assign ld1_live = load_1_RF_EX && valid1_RF_EX;
  assign ld2_live = load_2_RF_EX && valid2_RF_EX;

  function automatic logic lu_src(input logic [3:0] s,
                                  input logic [2:0] d1, input logic l1,
                                  input logic [2:0] d2, input logic l2);
    return (l1 && src_hit(s, d1)) || (l2 && src_hit(s, d2));
  endfunction

  assign lu_slot1 = valid1_ID_RF &&
                    (lu_src(src1_1_ID_RF, dest_1_RF_EX, ld1_live, dest_2_RF_EX, ld2_live) ||
                     lu_src(src2_1_ID_RF, dest_1_RF_EX, ld1_live, dest_2_RF_EX, ld2_live));
  assign lu_slot2 = valid2_ID_RF &&
                    (lu_src(src1_2_ID_RF, dest_1_RF_EX, ld1_live, dest_2_RF_EX, ld2_live) ||
                     lu_src(src2_2_ID_RF, dest_1_RF_EX, ld1_live, dest_2_RF_EX, ld2_live));

  // WAW between the slots is deliberately ignored: in-order write-back
  // already resolves it.
  assign raw12 = valid1_ID_RF && valid2_ID_RF && wb_1_ID_RF &&
                 (src_hit(src1_2_ID_RF, dest_1_ID_RF) ||
                  src_hit(src2_2_ID_RF, dest_1_ID_RF));

  // Next-state and outputs. Priority in every state: flush, LU, RAW12, normal.
  always_comb begin
    state_d      = state_q;
    hold_ID_RF   = 1'b0;
    issue_valid1 = 1'b0;
    issue_valid2 = 1'b0;
    split_active = 1'b0;
    stall_inc    = 1'b0;
    split_inc    = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        if (flush) begin
          state_d = ST_ISSUE;
        end else if (lu_slot1 || lu_slot2) begin
          hold_ID_RF = 1'b1;
          stall_inc  = 1'b1;
        end else if (raw12) begin
          issue_valid1 = valid1_ID_RF;
          hold_ID_RF   = 1'b1;
          split_inc    = 1'b1;
          state_d      = ST_SPLIT;
        end else begin
          issue_valid1 = valid1_ID_RF;
          issue_valid2 = valid2_ID_RF;
        end
      end
      ST_SPLIT: begin
        // Slot 1 already left; only slot 2 sources can still stall.
        split_active = 1'b1;
        if (flush) begin
          state_d = ST_ISSUE;
        end else if (lu_slot2) begin
          hold_ID_RF = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          issue_valid2 = valid2_ID_RF;
          state_d      = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    // Keep the pipeline quiet while reset is held.
    if (!rst_n) begin
      hold_ID_RF   = 1'b0;
      issue_valid1 = 1'b0;
      issue_valid2 = 1'b0;
      split_active = 1'b0;
      stall_inc    = 1'b0;
      split_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, split_cnt_q;

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      split_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (split_inc && (split_cnt_q != {CNT_W{1'b1}})) begin
        split_cnt_q <= split_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign split_count  = split_cnt_q;
`else
  logic unused_cnt_events;
  assign unused_cnt_events = stall_inc ^ split_inc;
  assign stall_cycles      = '0;
  assign split_count       = '0;
`endif

  // Slot 2 destination/write-back only matter to WAW, which needs no action.
  logic unused_slot2_dest;
  assign unused_slot2_dest = ^{dest_2_ID_RF, wb_2_ID_RF};

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_hazard_ctrl
//
// Directed test-plan scenarios followed by randomized traffic. Every cycle the
// driver applies one input vector, a behavioural model computes the expected
// outputs from the hazard rules and pushes them onto exp_q; a monitor on the
// falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_dual_issue_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int EXP_W = 4 + 2 * CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic       flush;
    logic [3:0] s11, s21, s12, s22;
    logic [2:0] d1, d2;
    logic       wb1, wb2, v1, v2;
    logic [2:0] xd1, xd2;
    logic       xl1, xl2, xv1, xv2;
  } in_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [3:0]       src1_1_ID_RF = '0, src2_1_ID_RF = '0;
  logic [3:0]       src1_2_ID_RF = '0, src2_2_ID_RF = '0;
  logic [2:0]       dest_1_ID_RF = '0, dest_2_ID_RF = '0;
  logic             wb_1_ID_RF = 1'b0, wb_2_ID_RF = 1'b0;
  logic             valid1_ID_RF = 1'b0, valid2_ID_RF = 1'b0;
  logic [2:0]       dest_1_RF_EX = '0, dest_2_RF_EX = '0;
  logic             load_1_RF_EX = 1'b0, load_2_RF_EX = 1'b0;
  logic             valid1_RF_EX = 1'b0, valid2_RF_EX = 1'b0;
  logic             flush = 1'b0;
  logic             hold_ID_RF, issue_valid1, issue_valid2, split_active;
  logic [CNT_W-1:0] stall_cycles, split_count;

  dual_issue_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src1_1_ID_RF (src1_1_ID_RF),
    .src2_1_ID_RF (src2_1_ID_RF),
    .src1_2_ID_RF (src1_2_ID_RF),
    .src2_2_ID_RF (src2_2_ID_RF),
    .dest_1_ID_RF (dest_1_ID_RF),
    .dest_2_ID_RF (dest_2_ID_RF),
    .wb_1_ID_RF   (wb_1_ID_RF),
    .wb_2_ID_RF   (wb_2_ID_RF),
    .valid1_ID_RF (valid1_ID_RF),
    .valid2_ID_RF (valid2_ID_RF),
    .dest_1_RF_EX (dest_1_RF_EX),
    .dest_2_RF_EX (dest_2_RF_EX),
    .load_1_RF_EX (load_1_RF_EX),
    .load_2_RF_EX (load_2_RF_EX),
    .valid1_RF_EX (valid1_RF_EX),
    .valid2_RF_EX (valid2_RF_EX),
    .flush        (flush),
    .hold_ID_RF   (hold_ID_RF),
    .issue_valid1 (issue_valid1),
    .issue_valid2 (issue_valid2),
    .split_active (split_active),
    .stall_cycles (stall_cycles),
    .split_count  (split_count)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: "slot 2 still owed" flag plus plain event counts.
  bit m_slot2_owed = 1'b0;
  int m_stalls = 0;
  int m_splits = 0;

  function automatic bit reads_reg(input logic [3:0] s, input logic [2:0] r);
    return s[3] && (s[2:0] == r);
  endfunction

  function automatic bit reads_inflight_load(input in_t v, input logic [3:0] s);
    return (v.xv1 && v.xl1 && reads_reg(s, v.xd1)) ||
           (v.xv2 && v.xl2 && reads_reg(s, v.xd2));
  endfunction

  function automatic int sat(input int c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  // Computes the outputs for this cycle and advances the model across the
  // clock edge that ends it.
  task automatic model_step(input in_t v, output logic [EXP_W-1:0] e);
    bit hold, i1, i2, split_o;
    bit slot1_waits, slot2_waits, lu, raw;
    int stall_o, splitc_o;
    hold = 0; i1 = 0; i2 = 0;
    split_o  = m_slot2_owed;
`ifdef HAZARD_PERF_CNT_EN
    stall_o  = sat(m_stalls);
    splitc_o = sat(m_splits);
`else
    stall_o  = 0;
    splitc_o = 0;
`endif
    if (!v.rst_n) begin
      split_o = 0;
      m_slot2_owed = 0;
      m_stalls = 0;
      m_splits = 0;
    end else begin
      slot1_waits = !m_slot2_owed && v.v1 &&
                    (reads_inflight_load(v, v.s11) || reads_inflight_load(v, v.s21));
      slot2_waits = v.v2 &&
                    (reads_inflight_load(v, v.s12) || reads_inflight_load(v, v.s22));
      lu  = slot1_waits || slot2_waits;
      raw = !m_slot2_owed && v.v1 && v.v2 && v.wb1 &&
            (reads_reg(v.s12, v.d1) || reads_reg(v.s22, v.d1));
      if (v.flush) begin
        m_slot2_owed = 0;
      end else if (lu) begin
        hold = 1;
        m_stalls++;
      end else if (raw) begin
        i1 = 1;
        hold = 1;
        m_slot2_owed = 1;
        m_splits++;
      end else begin
        i1 = m_slot2_owed ? 1'b0 : v.v1;
        i2 = v.v2;
        m_slot2_owed = 0;
      end
    end
    e = {hold, i1, i2, split_o, CNT_W'(stall_o), CNT_W'(splitc_o)};
  endtask

  // ---------------- driver ----------------
  task automatic step(input in_t v);
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    rst_n        = v.rst_n;
    flush        = v.flush;
    src1_1_ID_RF = v.s11;  src2_1_ID_RF = v.s21;
    src1_2_ID_RF = v.s12;  src2_2_ID_RF = v.s22;
    dest_1_ID_RF = v.d1;   dest_2_ID_RF = v.d2;
    wb_1_ID_RF   = v.wb1;  wb_2_ID_RF   = v.wb2;
    valid1_ID_RF = v.v1;   valid2_ID_RF = v.v2;
    dest_1_RF_EX = v.xd1;  dest_2_RF_EX = v.xd2;
    load_1_RF_EX = v.xl1;  load_2_RF_EX = v.xl2;
    valid1_RF_EX = v.xv1;  valid2_RF_EX = v.xv2;
    model_step(v, e);
    exp_q.push_back(e);
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] rand_src();
    return {($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0, 3'($urandom_range(3, 0))};
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rst_n = ($urandom_range(63, 0) != 0);
    v.flush = ($urandom_range(15, 0) == 0);
    v.s11 = rand_src(); v.s21 = rand_src();
    v.s12 = rand_src(); v.s22 = rand_src();
    v.d1  = 3'($urandom_range(3, 0));
    v.d2  = 3'($urandom_range(3, 0));
    v.wb1 = 1'($urandom_range(1, 0)); v.wb2 = 1'($urandom_range(1, 0));
    v.v1  = ($urandom_range(7, 0) != 0); v.v2 = ($urandom_range(7, 0) != 0);
    v.xd1 = 3'($urandom_range(3, 0));
    v.xd2 = 3'($urandom_range(3, 0));
    v.xl1 = ($urandom_range(3, 0) == 0); v.xl2 = ($urandom_range(3, 0) == 0);
    v.xv1 = 1'($urandom_range(1, 0)); v.xv2 = 1'($urandom_range(1, 0));
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e, got;
    cycle++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {hold_ID_RF, issue_valid1, issue_valid2, split_active,
             stall_cycles, split_count};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got hold=%b issue=%b%b split=%b stall=%0d splits=%0d, expected hold=%b issue=%b%b split=%b stall=%0d splits=%0d",
                 cycle, got[EXP_W-1], got[EXP_W-2], got[EXP_W-3], got[EXP_W-4],
                 got[2*CNT_W-1:CNT_W], got[CNT_W-1:0],
                 e[EXP_W-1], e[EXP_W-2], e[EXP_W-3], e[EXP_W-4],
                 e[2*CNT_W-1:CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t v;

    // Reset held 2 cycles with an intra-pair RAW present.
    v = idle();
    v.v1 = 1; v.v2 = 1; v.wb1 = 1; v.d1 = 3'd5; v.s22 = 4'b1101;
    v.rst_n = 0;
    step(v);
    step(v);
    step(idle());

    // Load-use on slot 1 for one cycle, then the pair issues.
    v = idle();
    v.v1 = 1; v.v2 = 1;
    v.xl1 = 1; v.xv1 = 1; v.xd1 = 3'd3; v.s11 = 4'b1011;
    step(v);
    v.xl1 = 0;
    step(v);

    // Intra-pair RAW split.
    v = idle();
    v.v1 = 1; v.v2 = 1; v.wb1 = 1; v.d1 = 3'd5; v.s22 = 4'b1101;
    step(v);
    step(v);
    step(idle());

    // Split plus load-use: slot 1 loads r2, slot 2 reads r2.
    v = idle();
    v.v1 = 1; v.v2 = 1; v.wb1 = 1; v.d1 = 3'd2; v.s12 = 4'b1010;
    step(v);
    v.xl1 = 1; v.xv1 = 1; v.xd1 = 3'd2;
    step(v);
    v.xl1 = 0; v.xv1 = 0;
    step(v);

    // Flush in the second cycle of a split.
    v = idle();
    v.v1 = 1; v.v2 = 1; v.wb1 = 1; v.d1 = 3'd4; v.s12 = 4'b1100;
    step(v);
    v.flush = 1;
    step(v);
    v.flush = 0;
    v.wb1 = 0;
    step(v);

    // Unused operand and invalid slots never hazard.
    v = idle();
    v.v1 = 1; v.v2 = 0; v.wb1 = 1; v.d1 = 3'd1; v.s12 = 4'b1001;
    v.xl1 = 1; v.xv1 = 1; v.xd1 = 3'd6; v.s11 = 4'b0110;
    step(v);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(rand_in());
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturation: hold a load-use long enough to overflow the counter.
    v = idle();
    step(v);
    v.v1 = 1; v.xl2 = 1; v.xv2 = 1; v.xd2 = 3'd7; v.s21 = 4'b1111;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      step(v);
    end
    step(idle());
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
